// File: rtl/if_stage_if.sv
// Fetch-stage port bundle: instruction SRAM and the fs -> ds handshake.
// The master side is the fetch stage; the slave side is SRAM plus decode.
interface if_stage_if;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;

  modport master (
    input  ds_allowin,
    input  br_taken,
    input  br_target,
    input  inst_sram_rdata,
    output inst_sram_en,
    output inst_sram_we,
    output inst_sram_addr,
    output inst_sram_wdata,
    output fs_to_ds_valid,
    output fs_to_ds_bus
  );

  modport slave (
    output ds_allowin,
    output br_taken,
    output br_target,
    output inst_sram_rdata,
    input  inst_sram_en,
    input  inst_sram_we,
    input  inst_sram_addr,
    input  inst_sram_wdata,
    input  fs_to_ds_valid,
    input  fs_to_ds_bus
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction SRAM and
// holds the fetched word locally while decode is stalled.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic       clk,
  input  logic       resetn,
  if_stage_if.master io
);

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] inst_buf;
  logic        inst_buf_valid;

  logic        to_fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;

  assign to_fs_valid = resetn;
  assign fs_ready_go = 1'b1;
  assign nextpc      = io.br_taken ? io.br_target : fs_pc + 32'd4;

  // A redirect frees the stage: the resident word is wrong-path.
  assign fs_allowin = ~fs_valid | io.ds_allowin | io.br_taken;

  assign io.inst_sram_en    = to_fs_valid & fs_allowin;
  assign io.inst_sram_we    = 1'b0;
  assign io.inst_sram_addr  = nextpc;
  assign io.inst_sram_wdata = 32'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_valid       <= 1'b0;
      fs_pc          <= RESET_PC - 32'd4;
      inst_buf       <= 32'd0;
      inst_buf_valid <= 1'b0;
    end else if (fs_allowin) begin
      fs_valid       <= to_fs_valid;
      fs_pc          <= nextpc;
      inst_buf_valid <= 1'b0;
    end else if (!inst_buf_valid) begin
      // SRAM data is only valid one cycle; latch it on stall entry
      inst_buf       <= io.inst_sram_rdata;
      inst_buf_valid <= 1'b1;
    end
  end

  assign fs_inst = inst_buf_valid ? inst_buf : io.inst_sram_rdata;

  assign io.fs_to_ds_valid = fs_valid & fs_ready_go & ~io.br_taken;
  assign io.fs_to_ds_bus   = {fs_pc, fs_inst};

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a program-order fetch model
// and a one-cycle-latency SRAM that returns junk when not read.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic clk;
  logic resetn;

  if_stage_if io ();

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (io.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: what decode should see, and where sequential fetch resumes
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  logic        sram_en_q;
  logic [31:0] sram_addr_q;
  logic        seen_squashed;

  a_br_pulse: assert property (
    @(posedge clk) disable iff (!resetn) io.br_taken |=> !io.br_taken
  ) else $error("br_taken held for two cycles");

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1c00_0008) return 32'h0280_0c21;
    return (a * 32'h9e37_79b1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called 1 time unit after a rising edge; returns the same way.
  task automatic step(input logic a, input logic b, input logic [31:0] t);
    logic        e_en;
    logic [31:0] e_addr;
    logic        got_en;
    logic [31:0] got_addr;
    e_en   = 1'b0;
    e_addr = 32'd0;
    io.ds_allowin = a;
    io.br_taken   = b;
    io.br_target  = t;
    io.inst_sram_rdata = sram_en_q ? mem_word(sram_addr_q) : $urandom();
    #3;
    if (!resetn) begin
      chk("rst_valid", io.fs_to_ds_valid, 0);
      chk("rst_en", io.inst_sram_en, 0);
      chk("rst_addr", io.inst_sram_addr, RESET_PC);
    end else begin
      e_en   = !m_valid || a || b;
      e_addr = b ? t : m_fetch;
      chk("en", io.inst_sram_en, e_en);
      chk("addr", io.inst_sram_addr, e_addr);
      chk("valid", io.fs_to_ds_valid, m_valid && !b);
      if (m_valid && !b)
        chk("bus", io.fs_to_ds_bus, {m_pc, mem_word(m_pc)});
      chk("we", io.inst_sram_we, 0);
      chk("wdata", io.inst_sram_wdata, 0);
      if (io.fs_to_ds_valid && a && io.fs_to_ds_bus[63:32] == 32'h1c00_0010)
        seen_squashed = 1'b1;
    end
    got_en   = io.inst_sram_en;
    got_addr = io.inst_sram_addr;
    @(posedge clk);
    sram_en_q   = got_en;
    sram_addr_q = got_addr;
    if (!resetn) begin
      m_valid = 1'b0;
      m_fetch = RESET_PC;
    end else if (e_en) begin
      m_valid = 1'b1;
      m_pc    = e_addr;
      m_fetch = e_addr + 32'd4;
    end
    #1;
  endtask

  initial begin
    logic        prev_br;
    logic        a;
    logic        b;
    logic [31:0] t;
    resetn        = 1'b0;
    io.ds_allowin = 1'b0;
    io.br_taken   = 1'b0;
    io.br_target  = 32'd0;
    io.inst_sram_rdata = 32'd0;
    m_valid       = 1'b0;
    m_pc          = 32'd0;
    m_fetch       = RESET_PC;
    sram_en_q     = 1'b0;
    sram_addr_q   = 32'd0;
    seen_squashed = 1'b0;
    @(posedge clk);
    #1;
    step(1, 0, 0);
    step(1, 0, 0);
    resetn = 1'b1;

    // release, sequential fetch, 3-cycle decode stall on 0x1c000008
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    // fs holds 0x1c000010: redirect squashes it
    step(1, 1, 32'h1c00_0100);
    step(1, 0, 0);
    chk("squash", seen_squashed, 0);
    // branch while the buffer is holding a stalled word
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 32'h1c00_0200);
    step(1, 0, 0);
    // wrap-around past the top of the address space
    step(1, 1, 32'hffff_fffc);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);

    // async reset while stalled
    step(0, 0, 0);
    step(0, 0, 0);
    io.inst_sram_rdata = $urandom();
    #1;
    resetn = 1'b0;
    #1;
    chk("async_valid", io.fs_to_ds_valid, 0);
    chk("async_en", io.inst_sram_en, 0);
    chk("async_addr", io.inst_sram_addr, RESET_PC);
    @(posedge clk);
    m_valid   = 1'b0;
    m_fetch   = RESET_PC;
    sram_en_q = 1'b0;
    #1;
    resetn = 1'b1;
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);

    // random traffic; branches are single-cycle pulses
    prev_br = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      a = ($urandom_range(0, 3) != 0);
      b = !prev_br && ($urandom_range(0, 6) == 0);
      case ($urandom_range(0, 3))
        0:       t = 32'hffff_fff8;
        default: t = $urandom() & 32'hffff_fffc;
      endcase
      step(a, b, t);
      prev_br = b;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage LoongArch pipeline; it owns the PC and drives the instruction SRAM.
- Hands {pc, inst} to the decode stage over a valid/allowin handshake.
- Accepts single-cycle branch redirects from decode and squashes the wrong-path instruction.
- Holds the fetched instruction in a local buffer while decode is stalled, because SRAM read data is valid only in the cycle after the read.

Parameters:
- RESET_PC, 32'h1c00_0000, address of the first instruction fetched after reset.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- ds_allowin  input  1  decode can accept an instruction this cycle
- br_taken  input  1  redirect request; single-cycle pulse per branch, already qualified by decode valid
- br_target  input  32  redirect address, sampled when br_taken=1
- inst_sram_en  output  1  SRAM read enable
- inst_sram_we  output  1  tied 0
- inst_sram_addr  output  32  fetch address (nextpc)
- inst_sram_wdata  output  32  tied 0
- inst_sram_rdata  input  32  read data, valid in the cycle after en=1
- fs_to_ds_valid  output  1  instruction offered to decode
- fs_to_ds_bus  output  64  {fs_pc[31:0], fs_inst[31:0]}

Behaviour:
- State registers:
  - fs_valid: 1b
  - fs_pc: 32b
  - inst_buf: 32b
  - inst_buf_valid: 1b
- Reset (resetn=0, asynchronous): fs_valid=0, fs_pc=RESET_PC-4, inst_buf=0, inst_buf_valid=0.
- Outputs during reset: fs_to_ds_valid=0, inst_sram_en=0, inst_sram_addr=RESET_PC.
- Pre-IF (combinational):
  - to_fs_valid = resetn.
  - nextpc = br_taken ? br_target : fs_pc+4, 32-bit wrap-around.
  - inst_sram_addr = nextpc.
  - inst_sram_en = to_fs_valid & fs_allowin.
- fs_ready_go = 1.
- fs_allowin = ~fs_valid | ds_allowin | br_taken. A redirect always frees the stage because the resident instruction is discarded.
- On clk when fs_allowin=1: fs_valid<=to_fs_valid, fs_pc<=nextpc, inst_buf_valid<=0.
- fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
- fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken. The squash is combinational, so the wrong-path instruction never reaches decode.
- Stall (fs_valid=1, ds_allowin=0, br_taken=0):
  - First stall cycle (inst_buf_valid=0): inst_buf<=inst_sram_rdata, inst_buf_valid<=1.
  - Later stall cycles: buffer holds; fs_pc holds; inst_sram_en=0.
- Handoff occurs when fs_to_ds_valid & ds_allowin, in the same cycle the next fetch is issued. Steady-state throughput is 1 instruction/cycle.
- Latency: an address is issued at edge N; the instruction is offered to decode in cycle N+1 (fs_valid=1 after edge N).
- Redirect:
  - Cycle of br_taken: fs_to_ds_valid=0, inst_sram_addr=br_target, inst_sram_en=1, irrespective of ds_allowin or buffer state.
  - Next edge: fs_pc=br_target, fs_valid=1, inst_buf_valid=0.
- Redirect with fs_valid=0 (empty stage): same target fetch; nothing to squash.
- br_taken held high for 2+ cycles is illegal. The bench checks it as an assertion.
- Reset mid-operation: all state clears immediately. The first fetch after resetn rises is RESET_PC; any buffered or in-flight instruction is lost.

Test Plan:
- Reset release: resetn 0->1 with ds_allowin=1.
  - Required: en=1, addr=0x1c000000 in the first cycle.
  - Next cycle: fs_to_ds_valid=1, bus={0x1c000000, rdata}.
  - Following addresses: 0x1c000004, 0x1c000008, one per cycle.
- Decode stall: ds_allowin=0 for 3 cycles while pc 0x1c000008 is in fs, rdata=0x02800c21 in the first cycle, then garbage.
  - Required: bus holds {0x1c000008, 0x02800c21} for all 3 cycles.
  - Required: en=0 during the stall.
  - On release: handoff, then fetch 0x1c00000c.
- Branch: br_taken=1, br_target=0x1c000100 while fs holds pc 0x1c000010.
  - Required in that cycle: fs_to_ds_valid=0, addr=0x1c000100.
  - Next cycle: bus pc=0x1c000100, and 0x1c000010 is never accepted.
- Branch during stall: ds_allowin=0 with inst_buf_valid=1, then br_taken pulses to 0x1c000200.
  - Required: the buffer is discarded.
  - Next cycle: fs_pc=0x1c000200, inst_buf_valid=0.
- Wrap: fs_pc=0xfffffffc, no branch -> nextpc=0x00000000.
- Async reset mid-stream: resetn low for 1 cycle while stalled.
  - Required: fs_to_ds_valid=0 immediately, without waiting for a clock edge.
  - After release: the first fetch is 0x1c000000.
